// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Load-use stall, bubble insertion and EX forwarding control for
//             the 5-stage addi/subi/R-type/lw/sw pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0]       c_FWD_RF    = 2'b00;
    localparam logic [1:0]       c_FWD_EXMEM = 2'b10;
    localparam logic [1:0]       c_FWD_MEMWB = 2'b01;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] dst;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
    } ex_slot_t;

    // MEM and WB are only ever looked at as producers, so they keep the
    // writer fields only.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] dst;
    } wr_slot_t;

    ex_slot_t         r_ex;
    wr_slot_t         r_mem;
    wr_slot_t         r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    ex_slot_t         w_id_slot;
    wr_slot_t         w_ex_wr;
    logic             w_lu;

    function automatic logic f_hit(input wr_slot_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.regwrite & (s.dst != '0) & (s.dst == r);
    endfunction

    function automatic logic [1:0] f_fwd_sel(
        input logic              use_r,
        input logic [REG_AW-1:0] r,
        input wr_slot_t          mem_s,
        input wr_slot_t          wb_s
    );
        if (use_r & f_hit(mem_s, r)) begin
            return c_FWD_EXMEM;
        end else if (use_r & f_hit(wb_s, r)) begin
            return c_FWD_MEMWB;
        end
        return c_FWD_RF;
    endfunction

    always_comb begin
        w_id_slot          = '0;
        w_id_slot.valid    = id_valid;
        w_id_slot.regwrite = id_regwrite;
        w_id_slot.memread  = id_memread;
        w_id_slot.dst      = id_dst;
        w_id_slot.rs       = id_rs;
        w_id_slot.rt       = id_rt;
        w_id_slot.use_rs   = id_use_rs;
        w_id_slot.use_rt   = id_use_rt;

        w_ex_wr            = '0;
        w_ex_wr.valid      = r_ex.valid;
        w_ex_wr.regwrite   = r_ex.regwrite;
        w_ex_wr.dst        = r_ex.dst;
    end

    // A load in EX cannot feed ID in time; a bubble in ID never stalls.
    always_comb begin
        w_lu = id_valid & r_ex.memread &
               ((id_use_rs & f_hit(w_ex_wr, id_rs)) |
                (id_use_rt & f_hit(w_ex_wr, id_rt)));
    end

    always_comb begin
        pc_write    = ~w_lu & ~mem_busy;
        ifid_write  = ~w_lu & ~mem_busy;
        idex_bubble = w_lu & ~mem_busy;
        ex_fwd_a    = c_FWD_RF;
        ex_fwd_b    = c_FWD_RF;
        if (r_ex.valid) begin
            ex_fwd_a = f_fwd_sel(r_ex.use_rs, r_ex.rs, r_mem, r_wb);
            ex_fwd_b = f_fwd_sel(r_ex.use_rt, r_ex.rt, r_mem, r_wb);
        end
        stall_cnt   = r_stall_cnt;
    end

    // A busy data memory freezes everything, including a pending stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else if (!mem_busy) begin
            r_wb  <= r_mem;
            r_mem <= w_ex_wr;
            if (w_lu) begin
                r_ex <= '0;
                if (r_stall_cnt != '1) begin
                    r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
                end
            end else begin
                r_ex <= w_id_slot;
            end
        end
    end

endmodule
`default_nettype wire
